tc_stack_word_adapter: RTL

- Sits directly upstream of the 8-bit push/pop stack component; converts multi-byte word push/pop requests from a CPU-side master into byte-serial push/pop strobes on the stack.
- Tracks stack occupancy in bytes and rejects overflow, underflow and conflicting requests, so the byte stack never wraps its pointer.
- Pop results are reassembled into a full word with a one-cycle response strobe.

---
 rtl/tc_stack_pkg.sv | 20 ++
 rtl/tc_stack_word_adapter_if.sv | 26 ++
 rtl/tc_stack_occupancy.sv | 35 +++
 rtl/tc_stack_word_adapter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/tc_stack_pkg.sv
// rtl/tc_stack_pkg.sv - shared types and constants for the word-to-byte stack adapter
// Contents: state_t (IDLE/PUSH/POP), err_t codes, TC_BYTE byte width.
package tc_stack_pkg;

    localparam int TC_BYTE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE     = 2'b00;
    localparam err_t ERR_OVF      = 2'b01;
    localparam err_t ERR_UNF      = 2'b10;
    localparam err_t ERR_CONFLICT = 2'b11;

endpackage

// File: rtl/tc_stack_word_adapter_if.sv
// rtl/tc_stack_word_adapter_if.sv - CPU-side word request/response bundle
// Signals: req_push, req_pop, wdata (master->slave); req_ready, rsp_valid, rdata, err (slave->master).
interface tc_stack_word_adapter_if #(
    parameter int WORD_BYTES = 2
);
    import tc_stack_pkg::*;

    logic                            req_push;
    logic                            req_pop;
    logic [TC_BYTE*WORD_BYTES-1:0]   wdata;
    logic                            req_ready;
    logic                            rsp_valid;
    logic [TC_BYTE*WORD_BYTES-1:0]   rdata;
    logic [1:0]                      err;

    modport master (
        output req_push, req_pop, wdata,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_push, req_pop, wdata,
        output req_ready, rsp_valid, rdata, err
    );

endinterface

// File: rtl/tc_stack_occupancy.sv
// rtl/tc_stack_occupancy.sv - byte occupancy counter moving in whole-word steps
// Ports: clk, rst (async, active-high), inc/dec (one word each), can_push/can_pop, count (bytes).
module tc_stack_occupancy #(
    parameter int DEPTH      = 256,
    parameter int WORD_BYTES = 2,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic          can_push,
    output logic          can_pop,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] PUSH_MAX = CW'(DEPTH - WORD_BYTES);
    localparam logic [CW-1:0] STEP     = CW'(WORD_BYTES);

    assign can_push = (count <= PUSH_MAX);
    assign can_pop  = (count >= STEP);

    // Guarded again here so the counter can never wrap even if a caller
    // strobes inc/dec without consulting can_push/can_pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && can_push) begin
            count <= count + STEP;
        end else if (dec && !inc && can_pop) begin
            count <= count - STEP;
        end
    end

endmodule

// File: rtl/tc_stack_word_adapter.sv
// rtl/tc_stack_word_adapter.sv - serialises word push/pop requests onto an 8-bit byte stack
// Ports: clk, rst (async, active-high), bus (word request/response, slave side), count (bytes held),
//        stk_push/stk_pop/stk_in to the byte stack, stk_out from the byte stack.
module tc_stack_word_adapter
    import tc_stack_pkg::*;
#(
    parameter int WORD_BYTES = 2,
    parameter int DEPTH      = 256,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    tc_stack_word_adapter_if.slave     bus,
    output logic [CW-1:0]              count,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [TC_BYTE-1:0]         stk_in,
    input  logic [TC_BYTE-1:0]         stk_out
);

    localparam int            W    = TC_BYTE * WORD_BYTES;
    localparam logic [2:0]    LAST = 3'(WORD_BYTES - 1);
    localparam logic [2:0]    FULL = 3'(WORD_BYTES);

    state_t        state;
    logic [2:0]    k;
    logic [W-1:0]  shreg;
    logic [W-1:0]  pop_shifted;
    logic          can_push;
    logic          can_pop;
    logic          accept_push;
    logic          accept_pop;
    err_t          req_err;

    tc_stack_occupancy #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES),
        .CW         (CW)
    ) u_occupancy (
        .clk      (clk),
        .rst      (rst),
        .inc      (accept_push),
        .dec      (accept_pop),
        .can_push (can_push),
        .can_pop  (can_pop),
        .count    (count)
    );

    assign bus.req_ready = (state == ST_IDLE) && !rst;

    // Popped bytes arrive MSB first; shifting each one in at the bottom
    // leaves the first byte in the top lane once the word is complete.
    assign pop_shifted = (shreg << TC_BYTE) | W'(stk_out);

    // Acceptance decision; only meaningful in IDLE, so busy-time requests
    // neither act nor raise an error.
    always_comb begin
        accept_push = 1'b0;
        accept_pop  = 1'b0;
        req_err     = ERR_NONE;
        if (state == ST_IDLE) begin
            if (bus.req_push && bus.req_pop) begin
                req_err = ERR_CONFLICT;
            end else if (bus.req_push) begin
                if (can_push) accept_push = 1'b1;
                else          req_err     = ERR_OVF;
            end else if (bus.req_pop) begin
                if (can_pop)  accept_pop  = 1'b1;
                else          req_err     = ERR_UNF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            k             <= '0;
            shreg         <= '0;
            stk_push      <= 1'b0;
            stk_pop       <= 1'b0;
            stk_in        <= '0;
            bus.rdata     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.err       <= ERR_NONE;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.err       <= req_err;
            case (state)
                ST_IDLE: begin
                    k <= '0;
                    if (accept_push) begin
                        state    <= ST_PUSH;
                        stk_push <= 1'b1;
                        stk_in   <= bus.wdata[TC_BYTE-1:0];
                        shreg    <= bus.wdata >> TC_BYTE;
                    end else if (accept_pop) begin
                        state   <= ST_POP;
                        stk_pop <= 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (k == LAST) begin
                        stk_push <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        stk_in <= shreg[TC_BYTE-1:0];
                        shreg  <= shreg >> TC_BYTE;
                        k      <= k + 3'd1;
                    end
                end
                ST_POP: begin
                    // k counts edges since acceptance minus one: pops are
                    // issued while k < WORD_BYTES, captures happen for k >= 1.
                    if (k == LAST) stk_pop <= 1'b0;
                    if (k != 3'd0) shreg <= pop_shifted;
                    if (k == FULL) begin
                        bus.rdata     <= pop_shifted;
                        bus.rsp_valid <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
